game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter PLAYERS, default 2: number of independent player channels (1..4).
REQ-002 Parameter COUNT_W, default 8: width of each player count and of the target count.
REQ-003 Parameter LEVELS, default 8: number of levels; completing level LEVELS-1 is victory.
REQ-004 Parameter TOL, default 0: maximum |count - target| that counts as a pass.
REQ-005 Parameter JUDGE_ALL, default 1: 1 means all players must pass; 0 means any one player passing is enough.
REQ-006 Parameters PRE_S/GAME_S/ANS_S/POST_S, defaults 3/10/5/3: phase durations in seconds (1..15).
REQ-007 Clk100M  in  1  sole clock; all logic rising-edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 secTick  in  1  one-cycle 1 Hz strobe, synchronous to Clk100M.
REQ-010 start  in  1  level-start request; sampled only in IDLE.
REQ-011 userUp, userDown  in  PLAYERS  per-player one-cycle increment/decrement blips.
REQ-012 target  in  COUNT_W  number of special symbols shown; captured on targetValid.
REQ-013 targetValid  in  1  one-cycle strobe from the symbol generator.
REQ-014 phase  out  3  current state encoding from the shared package.
REQ-015 curLevel  out  clog2(LEVELS)  current level index.
REQ-016 secsLeft  out  4  seconds remaining in the current timed phase.
REQ-017 startGen, stopGen  out  1  one-cycle pulses to the symbol generator.
REQ-018 userCount  out  PLAYERS*COUNT_W  packed per-player counts.
REQ-019 passMask  out  PLAYERS  per-player pass flags, valid in POST.
REQ-020 victory, lose  out  1  sticky terminal flags.

Function
REQ-021 States: IDLE, PRE, GAME, ANSWER, POST, WIN, LOSE.
REQ-022 IDLE->PRE on start=1: load secsLeft=PRE_S and clear all counts and the captured target.
REQ-023 In PRE, GAME, ANSWER and POST, each secTick decrements secsLeft; on the tick where secsLeft=1, advance and reload with the next phase duration.
REQ-024 PRE->GAME: assert startGen for exactly one cycle, in the transition cycle.
REQ-025 GAME->ANSWER: assert stopGen for exactly one cycle.
REQ-026 Player counts change only in GAME and ANSWER.
REQ-027 up and down in the same cycle leave the count unchanged.
REQ-028 Counts saturate at 0 and at 2^COUNT_W-1; no wrap-around.
REQ-029 target is captured on any targetValid in GAME; targetValid in other states is ignored; the last strobe wins.
REQ-030 ANSWER->POST: register passMask[i] = (|userCount[i] - target| <= TOL), using COUNT_W+1-bit difference arithmetic.
REQ-031 POST expiry with a passing result (per JUDGE_ALL) and curLevel < LEVELS-1: increment curLevel and go to IDLE.
REQ-032 POST expiry with a passing result and curLevel = LEVELS-1: go to WIN and set victory.
REQ-033 POST expiry with a failing result: go to LOSE and set lose.
REQ-034 WIN and LOSE hold until reset; start is ignored in both.
REQ-035 secTick coinciding with a state transition is consumed by the transition only.
REQ-036 Output latency: all outputs are registered; phase changes in the cycle after the deciding tick.

Reset
REQ-037 Reset values: phase=IDLE, curLevel=0, secsLeft=0, counts=0, target=0, passMask=0, startGen/stopGen/victory/lose=0.
REQ-038 Reset asserted mid-phase aborts the level the next cycle with no stopGen pulse.
REQ-039 Reset has priority over every other input.

Structure
REQ-040 Package game_pkg: phase encoding, default duration constants, and the PLAYERS limit.
REQ-041 One sub-module sym_user_counter (saturating up/down, enable, clear), instantiated PLAYERS times.

Verification
REQ-042 Timing, defaults: start, then secTicks -> startGen 3 ticks after start, stopGen 10 ticks later, POST 5 ticks later, IDLE with curLevel=1 after 3 more ticks.
REQ-043 Pass/fail, defaults: target=7; player0 counts 7, player1 counts 6 -> passMask=01, lose=1 (JUDGE_ALL=1); same stimulus with JUDGE_ALL=0 -> curLevel increments.
REQ-044 Saturation, COUNT_W=8: 300 up blips -> count=255; 5 down blips at 0 -> count=0; simultaneous up+down -> no change.
REQ-045 Victory, LEVELS=2: pass both levels -> victory=1, phase=WIN; further start is ignored.
REQ-046 Abort: reset asserted in GAME with secsLeft=4 -> next cycle phase=IDLE, all outputs at reset values, no stopGen.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: phase encoding, default phase durations and limits shared by the sequencer.
package game_pkg;
    typedef enum logic [2:0] {IDLE, PRE, GAME, ANSWER, POST, WIN, LOSE} phase_e;
    localparam int PRE_S_DEF = 3;
    localparam int GAME_S_DEF = 10;
    localparam int ANS_S_DEF = 5;
    localparam int POST_S_DEF = 3;
    localparam int MAX_PLAYERS = 4;
    function automatic int lvl_w(input int levels);
        return levels > 1 ? $clog2(levels) : 1;
    endfunction
endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: stimulus inputs and registered status outputs of the level sequencer.
interface game_sequencer_if import game_pkg::*; #(
    parameter int PLAYERS = 2,
    parameter int COUNT_W = 8,
    parameter int LEVELS = 8
) ();
    localparam int LW = lvl_w(LEVELS);
    logic secTick;
    logic start;
    logic [PLAYERS-1:0] userUp;
    logic [PLAYERS-1:0] userDown;
    logic [COUNT_W-1:0] target;
    logic targetValid;
    phase_e phase;
    logic [LW-1:0] curLevel;
    logic [3:0] secsLeft;
    logic startGen;
    logic stopGen;
    logic [PLAYERS*COUNT_W-1:0] userCount;
    logic [PLAYERS-1:0] passMask;
    logic victory;
    logic lose;
    modport master (
        output secTick, start, userUp, userDown, target, targetValid,
        input phase, curLevel, secsLeft, startGen, stopGen, userCount, passMask, victory, lose
    );
    modport slave (
        input secTick, start, userUp, userDown, target, targetValid,
        output phase, curLevel, secsLeft, startGen, stopGen, userCount, passMask, victory, lose
    );
endinterface

// File: rtl/sym_user_counter.sv
// sym_user_counter: per-player saturating up/down counter with enable and synchronous clear.
module sym_user_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         up_i,
    input  logic         down_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        count_d = !en_i || up_i == down_i ? count_q :
                  up_i ? (&count_q ? count_q : count_q + W'(1)) :
                  (|count_q ? count_q - W'(1) : count_q);
    end
    always_ff @(posedge clk) begin
        if (rst || clr_i) count_q <= '0;
        else count_q <= count_d;
    end
    assign count_o = count_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: timed PRE/GAME/ANSWER/POST level flow with per-player counting and judging.
module game_sequencer import game_pkg::*; #(
    parameter int PLAYERS = 2,
    parameter int COUNT_W = 8,
    parameter int LEVELS = 8,
    parameter int TOL = 0,
    parameter int JUDGE_ALL = 1,
    parameter int PRE_S = PRE_S_DEF,
    parameter int GAME_S = GAME_S_DEF,
    parameter int ANS_S = ANS_S_DEF,
    parameter int POST_S = POST_S_DEF
) (
    input logic Clk100M,
    input logic reset,
    game_sequencer_if.slave bus
);
    localparam int LW = lvl_w(LEVELS);
    localparam int DW = COUNT_W + 1;
    if (PLAYERS < 1 || PLAYERS > MAX_PLAYERS) begin : g_bad_players
        $error("PLAYERS out of range");
    end
    phase_e phase_q;
    logic [LW-1:0] lvl_q;
    logic [3:0] secs_q;
    logic start_gen_q, stop_gen_q, victory_q, lose_q;
    logic [COUNT_W-1:0] target_q;
    logic [PLAYERS-1:0] pass_q, pass_d;
    logic [COUNT_W-1:0] cnt [PLAYERS];
    logic [DW-1:0] diff [PLAYERS];
    logic cnt_en, cnt_clr, timed, expire, passed;
    assign cnt_en = phase_q == GAME || phase_q == ANSWER;
    assign cnt_clr = phase_q == IDLE && bus.start;
    assign timed = phase_q inside {PRE, GAME, ANSWER, POST};
    assign expire = bus.secTick && secs_q == 4'd1;
    assign passed = JUDGE_ALL != 0 ? &pass_q : |pass_q;
    // one extra bit keeps the signed difference exact over the full count range
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            diff[p] = {1'b0, cnt[p]} - {1'b0, target_q};
            pass_d[p] = (diff[p][COUNT_W] ? -diff[p] : diff[p]) <= DW'(TOL);
        end
    end
    for (genvar i = 0; i < PLAYERS; i++) begin : g_cnt
        sym_user_counter #(.W(COUNT_W)) u_cnt (
            .clk(Clk100M), .rst(reset), .en_i(cnt_en), .clr_i(cnt_clr),
            .up_i(bus.userUp[i]), .down_i(bus.userDown[i]), .count_o(cnt[i])
        );
        assign bus.userCount[i*COUNT_W +: COUNT_W] = cnt[i];
    end
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            phase_q <= IDLE;
            lvl_q <= '0;
            secs_q <= '0;
            start_gen_q <= 1'b0;
            stop_gen_q <= 1'b0;
            victory_q <= 1'b0;
            lose_q <= 1'b0;
            target_q <= '0;
            pass_q <= '0;
        end else begin
            start_gen_q <= 1'b0;
            stop_gen_q <= 1'b0;
            if (timed && bus.secTick && secs_q > 4'd1) secs_q <= secs_q - 4'd1;
            case (phase_q)
                IDLE: if (bus.start) begin
                    phase_q <= PRE;
                    secs_q <= 4'(PRE_S);
                    target_q <= '0;
                end
                PRE: if (expire) begin
                    phase_q <= GAME;
                    secs_q <= 4'(GAME_S);
                    start_gen_q <= 1'b1;
                end
                GAME: begin
                    if (bus.targetValid) target_q <= bus.target;
                    if (expire) begin
                        phase_q <= ANSWER;
                        secs_q <= 4'(ANS_S);
                        stop_gen_q <= 1'b1;
                    end
                end
                ANSWER: if (expire) begin
                    phase_q <= POST;
                    secs_q <= 4'(POST_S);
                    pass_q <= pass_d;
                end
                POST: if (expire) begin
                    secs_q <= '0;
                    if (!passed) begin
                        phase_q <= LOSE;
                        lose_q <= 1'b1;
                    end else if (lvl_q == LW'(LEVELS - 1)) begin
                        phase_q <= WIN;
                        victory_q <= 1'b1;
                    end else begin
                        phase_q <= IDLE;
                        lvl_q <= lvl_q + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.phase = phase_q;
    assign bus.curLevel = lvl_q;
    assign bus.secsLeft = secs_q;
    assign bus.startGen = start_gen_q;
    assign bus.stopGen = stop_gen_q;
    assign bus.passMask = pass_q;
    assign bus.victory = victory_q;
    assign bus.lose = lose_q;
endmodule
